// File: rtl/mod_i2c_codec_target_pkg.sv
// WM8731 control-port constants: register map, power-on defaults, fault codes, target FSM states.
package pkg_wm8731;

    localparam int         NUM_REGS   = 10;
    localparam logic [6:0] LAST_REG   = 7'h09;
    localparam logic [6:0] REG_ACTIVE = 7'h09;
    localparam logic [6:0] REG_RESET  = 7'h0F;

    // Packed MSB-first, so R9 is listed first and R0 last.
    localparam logic [NUM_REGS-1:0][8:0] REG_DEFAULTS = {
        9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
        9'h00A, 9'h079, 9'h079, 9'h097, 9'h097
    };

    localparam logic [3:0] FAULT_NONE      = 4'd0;
    localparam logic [3:0] FAULT_READ_REQ  = 4'd1;
    localparam logic [3:0] FAULT_BAD_REG   = 4'd2;
    localparam logic [3:0] FAULT_OVERLONG  = 4'd3;
    localparam logic [3:0] FAULT_TRUNCATED = 4'd4;

    typedef enum logic [3:0] {
        ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_REG, ST_REG_ACK,
        ST_DATA, ST_DATA_ACK, ST_COMMIT, ST_IGNORE
    } state_t;

endpackage

// File: rtl/mod_i2c_line_sync.sv
// Bus line conditioner: 2-FF synchroniser, optional agreement filter, rise/fall detect.
// Filter enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module mod_i2c_line_sync
`ifdef I2C_TARGET_GLITCH_FILTER_EN
#(
    parameter int FILTER_LEN = 3
)
`endif
(
    input  logic clk,
    input  logic rst_n,
    input  logic line,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [1:0] sync;
    logic       prev;

    // Idle bus is high, so every stage resets to 1 to avoid a false edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], line};
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    logic [FILTER_LEN-1:0] hist;
    logic                  filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '1;
            filt <= 1'b1;
        end else begin
            hist <= {hist[FILTER_LEN-2:0], sync[1]};
            if (&hist)       filt <= 1'b1;
            else if (~|hist) filt <= 1'b0;
        end
    end

    assign level = filt;
`else
    assign level = sync[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= level;
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/mod_i2c_codec_target.sv
// WM8731-style I2C write-only target with a 9-bit register file exposed to the fabric.
// Optional SCL/SDA glitch filter: define I2C_TARGET_GLITCH_FILTER_EN.
module mod_i2c_codec_target
    import pkg_wm8731::*;
#(
    parameter logic [6:0] TARGET_I2C_ADDR = 7'b0011010
`ifdef I2C_TARGET_GLITCH_FILTER_EN
    , parameter int FILTER_LEN = 3
`endif
) (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_i2c_scl,
    inout  wire        b_i2c_sdat,
    input  logic [3:0] i_rd_reg,
    output logic [8:0] o_rd_data,
    output logic       o_write_valid,
    output logic [6:0] o_write_reg,
    output logic [8:0] o_write_data,
    output logic       o_active,
    output logic [3:0] o_fault_code,
    output logic [3:0] o_current_state
);

    state_t                    state, state_nxt;
    logic                      scl, scl_rise, scl_fall, sda, sda_rise, sda_fall;
    logic                      start, stop, byte_done, addr_hit, ack_state, trunc;
    logic [7:0]                sr, data_lo;
    logic [3:0]                bit_cnt;
    logic [6:0]                reg_addr;
    logic                      data_hi, sda_drv, over;
    logic [NUM_REGS-1:0][8:0]  regs;

    mod_i2c_line_sync
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        #(.FILTER_LEN(FILTER_LEN))
`endif
        u_scl_sync (.clk(i_clk), .rst_n(i_nrst), .line(i_i2c_scl),
                    .level(scl), .rise(scl_rise), .fall(scl_fall));

    mod_i2c_line_sync
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        #(.FILTER_LEN(FILTER_LEN))
`endif
        u_sda_sync (.clk(i_clk), .rst_n(i_nrst), .line(b_i2c_sdat),
                    .level(sda), .rise(sda_rise), .fall(sda_fall));

    assign b_i2c_sdat = sda_drv ? 1'b0 : 1'bz;

    assign start     = sda_fall & scl;
    assign stop      = sda_rise & scl;
    assign byte_done = scl_fall && (bit_cnt == 4'd8);
    assign addr_hit  = (sr[7:1] == TARGET_I2C_ADDR);
    assign ack_state = (state == ST_ADDR_ACK) || (state == ST_REG_ACK) || (state == ST_DATA_ACK);
    assign trunc     = ack_state || (state == ST_REG) || (state == ST_DATA);

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:     ;
            ST_ADDR:     if (byte_done) state_nxt = (addr_hit && !sr[0]) ? ST_ADDR_ACK : ST_IGNORE;
            ST_ADDR_ACK: if (scl_fall)  state_nxt = ST_REG;
            ST_REG:      if (byte_done) state_nxt = ST_REG_ACK;
            ST_REG_ACK:  if (scl_fall)  state_nxt = ST_DATA;
            ST_DATA:     if (byte_done) state_nxt = ST_DATA_ACK;
            ST_DATA_ACK: if (scl_fall)  state_nxt = ST_COMMIT;
            ST_COMMIT:   state_nxt = ST_IGNORE;
            ST_IGNORE:   ;
            default:     state_nxt = ST_IDLE;
        endcase
        if (start)     state_nxt = ST_ADDR;
        else if (stop) state_nxt = ST_IDLE;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            regs          <= REG_DEFAULTS;
            sr            <= '0;
            bit_cnt       <= '0;
            reg_addr      <= '0;
            data_hi       <= 1'b0;
            data_lo       <= '0;
            sda_drv       <= 1'b0;
            over          <= 1'b0;
            o_write_valid <= 1'b0;
            o_write_reg   <= '0;
            o_write_data  <= '0;
            o_fault_code  <= FAULT_NONE;
        end else begin
            o_write_valid <= 1'b0;

            if (start || stop) begin
                bit_cnt <= '0;
            end else if (scl_rise && (state == ST_ADDR || state == ST_REG ||
                                      state == ST_DATA || state == ST_IGNORE)) begin
                sr      <= {sr[6:0], sda};
                bit_cnt <= bit_cnt + 4'd1;
            end else if (byte_done) begin
                // In IGNORE the ack-slot rise wraps 15 -> 0, keeping byte framing aligned.
                bit_cnt <= (state_nxt == ST_IGNORE) ? 4'd15 : 4'd0;
            end

            if (byte_done && state == ST_REG) begin
                reg_addr <= sr[7:1];
                data_hi  <= sr[0];
            end
            if (byte_done && state == ST_DATA) data_lo <= sr;

            if (start || stop)                  sda_drv <= 1'b0;
            else if (scl_fall && ack_state)     sda_drv <= 1'b0;
            else if (byte_done && (state_nxt == ST_ADDR_ACK || state_nxt == ST_REG_ACK ||
                                   state_nxt == ST_DATA_ACK))
                                                sda_drv <= 1'b1;

            if (start || stop)             over <= 1'b0;
            else if (state == ST_COMMIT)   over <= 1'b1;

            if (state == ST_COMMIT) begin
                if (reg_addr <= LAST_REG || reg_addr == REG_RESET) begin
                    if (reg_addr == REG_RESET) regs <= REG_DEFAULTS;
                    else                       regs[reg_addr[3:0]] <= {data_hi, data_lo};
                    o_write_valid <= 1'b1;
                    o_write_reg   <= reg_addr;
                    o_write_data  <= {data_hi, data_lo};
                end else begin
                    o_fault_code <= FAULT_BAD_REG;
                end
            end

            if (start || stop) begin
                if (trunc)      o_fault_code <= FAULT_TRUNCATED;
                else if (start) o_fault_code <= FAULT_NONE;
            end else if (byte_done && state == ST_ADDR && addr_hit && sr[0]) begin
                o_fault_code <= FAULT_READ_REQ;
            end else if (byte_done && state == ST_IGNORE && over) begin
                o_fault_code <= FAULT_OVERLONG;
            end
        end
    end

    assign o_rd_data       = (i_rd_reg <= 4'd9) ? regs[i_rd_reg] : 9'h000;
    assign o_active        = regs[REG_ACTIVE[3:0]][0];
    assign o_current_state = state;

endmodule

// File: tb/tb_mod_i2c_codec_target.sv
// Directed bench for mod_i2c_codec_target: bit-banged I2C master with pull-up on SDA.
module tb_mod_i2c_codec_target;
    import pkg_wm8731::*;

    logic       i_clk = 1'b0;
    logic       i_nrst = 1'b0;
    logic       scl = 1'b1;
    logic       sda_low = 1'b0;
    logic [3:0] i_rd_reg = 4'd0;
    logic [8:0] o_rd_data;
    logic       o_write_valid;
    logic [6:0] o_write_reg;
    logic [8:0] o_write_data;
    logic       o_active;
    logic [3:0] o_fault_code;
    logic [3:0] o_current_state;
    wire        sda;

    int vectors = 0;
    int fails   = 0;
    int wv_cnt  = 0;

    pullup (sda);
    assign sda = sda_low ? 1'b0 : 1'bz;

    always #5 i_clk = ~i_clk;
    always @(negedge i_clk) if (o_write_valid) wv_cnt++;

    mod_i2c_codec_target dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_i2c_scl(scl), .b_i2c_sdat(sda),
        .i_rd_reg(i_rd_reg), .o_rd_data(o_rd_data), .o_write_valid(o_write_valid),
        .o_write_reg(o_write_reg), .o_write_data(o_write_data), .o_active(o_active),
        .o_fault_code(o_fault_code), .o_current_state(o_current_state)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    task automatic i2c_start;
        scl = 1'b1; sda_low = 1'b0; hold(10);
        sda_low = 1'b1; hold(10);
        scl = 1'b0; hold(5);
    endtask

    task automatic i2c_stop;
        sda_low = 1'b1; hold(5);
        scl = 1'b1; hold(10);
        sda_low = 1'b0; hold(15);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_low = ~b[i]; hold(5);
            scl = 1'b1; hold(10);
            scl = 1'b0; hold(5);
        end
    endtask

    task automatic ack_clk(output logic ack);
        sda_low = 1'b0; hold(5);
        scl = 1'b1; hold(5);
        ack = (sda === 1'b0);
        hold(5);
        scl = 1'b0; hold(5);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        ack_clk(ack);
    endtask

    logic a0, a1, a2, a3;
    int   wv0;
    logic seen_addr, exp_seen;

    initial begin
        hold(3);
        chk("rst_sda_released", sda, 1'b1);
        i_nrst = 1'b1;
        hold(3);
        i_rd_reg = 4'd4; #1; chk("rst_r4", o_rd_data, 9'h00A);
        i_rd_reg = 4'd6; #1; chk("rst_r6", o_rd_data, 9'h09F);
        chk("rst_active", o_active, 1'b0);
        chk("rst_state", o_current_state, ST_IDLE);
        chk("rst_fault", o_fault_code, 4'd0);
        chk("rst_wreg", o_write_reg, 7'd0);
        chk("rst_wdata", o_write_data, 9'd0);
        chk("rst_sda", sda, 1'b1);

        // R6 <= 0x006
        wv0 = wv_cnt;
        i2c_start; send_byte(8'h34, a0); send_byte(8'h0C, a1); send_byte(8'h06, a2); i2c_stop;
        chk("w6_ack", {a0, a1, a2}, 3'b111);
        chk("w6_strobe_cnt", wv_cnt - wv0, 1);
        chk("w6_wreg", o_write_reg, 7'd6);
        chk("w6_wdata", o_write_data, 9'h006);
        i_rd_reg = 4'd6; #1; chk("w6_readback", o_rd_data, 9'h006);
        chk("w6_fault", o_fault_code, 4'd0);
        chk("w6_idle", o_current_state, ST_IDLE);

        // foreign address
        wv0 = wv_cnt;
        i2c_start; send_byte(8'h36, a0); i2c_stop;
        chk("foreign_nack", a0, 1'b0);
        chk("foreign_strobe", wv_cnt - wv0, 0);
        chk("foreign_r6", o_rd_data, 9'h006);
        chk("foreign_fault", o_fault_code, 4'd0);

        // R9 <= 0x001, then reset register
        i2c_start; send_byte(8'h34, a0); send_byte(8'h12, a1); send_byte(8'h01, a2); i2c_stop;
        chk("r9_active", o_active, 1'b1);
        i_rd_reg = 4'd9; #1; chk("r9_readback", o_rd_data, 9'h001);
        wv0 = wv_cnt;
        i2c_start; send_byte(8'h34, a0); send_byte(8'h1E, a1); send_byte(8'h00, a2); i2c_stop;
        chk("rst_reg_ack", {a0, a1, a2}, 3'b111);
        chk("rst_reg_strobe", wv_cnt - wv0, 1);
        chk("rst_reg_wreg", o_write_reg, 7'h0F);
        chk("rst_reg_active", o_active, 1'b0);
        i_rd_reg = 4'd6; #1; chk("rst_reg_r6", o_rd_data, 9'h09F);
        i_rd_reg = 4'd0; #1; chk("rst_reg_r0", o_rd_data, 9'h097);

        // truncated frame, then read request
        wv0 = wv_cnt;
        i2c_start; send_byte(8'h34, a0); send_byte(8'h0C, a1); i2c_stop;
        chk("trunc_strobe", wv_cnt - wv0, 0);
        chk("trunc_fault", o_fault_code, 4'd4);
        i_rd_reg = 4'd6; #1; chk("trunc_r6", o_rd_data, 9'h09F);
        i2c_start;
        chk("start_clears_fault", o_fault_code, 4'd0);
        send_byte(8'h35, a0);
        chk("read_nack", a0, 1'b0);
        chk("read_fault", o_fault_code, 4'd1);
        i2c_stop;

        // unmapped register
        wv0 = wv_cnt;
        i2c_start; send_byte(8'h34, a0); send_byte(8'h20, a1); send_byte(8'h00, a2); i2c_stop;
        chk("badreg_ack", {a0, a1, a2}, 3'b111);
        chk("badreg_strobe", wv_cnt - wv0, 0);
        chk("badreg_fault", o_fault_code, 4'd2);

        // overlong frame: R5 <= 0x055 then a 4th byte
        wv0 = wv_cnt;
        i2c_start; send_byte(8'h34, a0); send_byte(8'h0A, a1); send_byte(8'h55, a2);
        send_byte(8'hAA, a3); i2c_stop;
        chk("over_ack", {a0, a1, a2, a3}, 4'b1110);
        chk("over_fault", o_fault_code, 4'd3);
        chk("over_strobe", wv_cnt - wv0, 1);
        i_rd_reg = 4'd5;  #1; chk("over_r5", o_rd_data, 9'h055);
        i_rd_reg = 4'd12; #1; chk("rd_out_of_range", o_rd_data, 9'h000);

        // reset while the target is driving ACK
        i2c_start; send_bits(8'h34); sda_low = 1'b0; hold(8);
        chk("midrst_ack_driven", sda, 1'b0);
        i_nrst = 1'b0; #1;
        chk("midrst_sda_released", sda, 1'b1);
        chk("midrst_state", o_current_state, ST_IDLE);
        i_rd_reg = 4'd5; #1; chk("midrst_r5_default", o_rd_data, 9'h008);
        hold(2);
        scl = 1'b1; hold(5);
        i_nrst = 1'b1; hold(10);

        // one-cycle SDA glitch with SCL high
        seen_addr = 1'b0;
        sda_low = 1'b1; hold(1);
        sda_low = 1'b0;
        for (int i = 0; i < 12; i++) begin
            hold(1);
            if (o_current_state == ST_ADDR) seen_addr = 1'b1;
        end
`ifdef I2C_TARGET_GLITCH_FILTER_EN
        exp_seen = 1'b0;
`else
        exp_seen = 1'b1;
`endif
        chk("glitch_start_decode", seen_addr, exp_seen);
        chk("glitch_final_idle", o_current_state, ST_IDLE);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
